// File: rtl/uart_arb_pkg.sv
// Shared constants and types for the uart_tx byte arbiter.
package uart_arb_pkg;

  localparam int          NUM_REQ          = 4;
  localparam logic [15:0] ACC_TIMEOUT_DFLT = 16'd1024;

  // One-hot encoding keeps each state decode to a single flop bit.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_WAIT_ACC  = 3'b010,
    ST_WAIT_DONE = 3'b100
  } arb_state_e;

  function automatic logic [1:0] rr_advance(input logic [1:0] winner);
    return winner + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] rot;
  logic [1:0] offset;

  // NOTE: combinational logic uses blocking assignments, and every output gets a
  // default before any branch so no path can infer a latch.
  always_comb begin
    offset = 2'd0;
    rot    = 4'({req, req} >> ptr);
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) offset = 2'(i);
    end
    winner = offset + ptr;
    any    = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from several requesters into uart_tx.
module uart_tx_arbiter #(
  parameter int          NUM_REQ     = uart_arb_pkg::NUM_REQ,
  parameter logic [15:0] ACC_TIMEOUT = uart_arb_pkg::ACC_TIMEOUT_DFLT
) (
  input  logic                   pclk_i,
  input  logic                   prst_n_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [7:0]             tx_pdata_o,
  output logic                   tx_pdata_valid_o,
  input  logic                   tx_pready_i,
  output logic [1:0]             owner_o,
  output logic                   busy_o,
  output logic                   err_timeout_o,
  output logic [15:0]            sent_count_o
);

  import uart_arb_pkg::*;

  localparam logic [15:0] ACC_LIMIT = ACC_TIMEOUT - 16'd1;

  arb_state_e  state_q, state_d;
  logic [1:0]  rr_ptr_q;
  logic [15:0] acc_cnt_q;

  logic [1:0]  pick_winner;
  logic        pick_any;

  logic        do_grant;
  logic        do_accept;
  logic        do_timeout;
  logic        do_done;
  logic        acc_tick;

  rr_pick4 u_pick (
    .req    (req_i),
    .ptr    (rr_ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // NOTE: every flop here (state, pointer, counters, output registers) is reset
  // asynchronously and updated with non-blocking assignments only.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_accept  = 1'b0;
    do_timeout = 1'b0;
    do_done    = 1'b0;
    acc_tick   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_pready_i && pick_any) begin
          do_grant = 1'b1;
          state_d  = ST_WAIT_ACC;
        end
      end
      ST_WAIT_ACC: begin
        // Acceptance is checked first so it wins over a coincident timeout.
        if (!tx_pready_i) begin
          do_accept = 1'b1;
          state_d   = ST_WAIT_DONE;
        end else if (acc_cnt_q == ACC_LIMIT) begin
          do_timeout = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          acc_tick = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        // Returning to IDLE here forces at least one idle cycle before the next grant.
        if (tx_pready_i) begin
          do_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      rr_ptr_q         <= 2'd0;
      acc_cnt_q        <= 16'd0;
      gnt_o            <= '0;
      tx_pdata_o       <= 8'h00;
      tx_pdata_valid_o <= 1'b0;
      owner_o          <= 2'd0;
      busy_o           <= 1'b0;
      err_timeout_o    <= 1'b0;
      sent_count_o     <= 16'd0;
    end else begin
      gnt_o         <= '0;
      err_timeout_o <= do_timeout;
      busy_o        <= (state_d != ST_IDLE);

      if (do_grant) begin
        gnt_o            <= NUM_REQ'(1) << pick_winner;
        tx_pdata_o       <= req_data_i[{pick_winner, 3'b000} +: 8];
        tx_pdata_valid_o <= 1'b1;
        owner_o          <= pick_winner;
        rr_ptr_q         <= rr_advance(pick_winner);
      end else if (do_accept || do_timeout) begin
        tx_pdata_valid_o <= 1'b0;
      end

      if (do_grant)      acc_cnt_q <= 16'd0;
      else if (acc_tick) acc_cnt_q <= acc_cnt_q + 16'd1;

      if (do_done) sent_count_o <= sent_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic        pready = 1'b1;

  logic [3:0]  gnt_o;
  logic [7:0]  tx_pdata_o;
  logic        tx_pdata_valid_o;
  logic [1:0]  owner_o;
  logic        busy_o;
  logic        err_timeout_o;
  logic [15:0] sent_count_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_sent = 16'd0;

  always #5 pclk = ~pclk;

  uart_tx_arbiter #(.NUM_REQ(4), .ACC_TIMEOUT(16'd16)) dut (
    .pclk_i           (pclk),
    .prst_n_i         (prst_n),
    .req_i            (req),
    .req_data_i       (req_data),
    .gnt_o            (gnt_o),
    .tx_pdata_o       (tx_pdata_o),
    .tx_pdata_valid_o (tx_pdata_valid_o),
    .tx_pready_i      (pready),
    .owner_o          (owner_o),
    .busy_o           (busy_o),
    .err_timeout_o    (err_timeout_o),
    .sent_count_o     (sent_count_o)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        pready;
    logic [3:0]  gnt;
    logic [7:0]  pdata;
    logic        valid;
    logic [1:0]  owner;
    logic        busy;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic [31:0] d, input logic p,
                              input logic [3:0] g, input logic [7:0] pd, input logic v,
                              input logic [1:0] o, input logic b, input logic e,
                              input logic [15:0] c);
    vec_t t;
    t.req = r; t.data = d; t.pready = p; t.gnt = g; t.pdata = pd;
    t.valid = v; t.owner = o; t.busy = b; t.err = e; t.cnt = c;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [32:0] outs();
    return {gnt_o, tx_pdata_o, tx_pdata_valid_o, owner_o, busy_o, err_timeout_o, sent_count_o};
  endfunction

  // Waits (bounded) for a grant with tx_pready_i high, then checks who won.
  task automatic wait_grant(input string name, input logic [3:0] exp_gnt,
                            input logic [7:0] exp_data, input logic [1:0] exp_owner);
    int waited = 0;
    pready = 1'b1;
    do begin
      tick();
      waited++;
    end while (gnt_o == 4'b0000 && waited < 10);
    check({name, " gnt"}, 64'(gnt_o), 64'(exp_gnt));
    check({name, " data/valid/owner"}, 64'({tx_pdata_o, tx_pdata_valid_o, owner_o}),
          64'({exp_data, 1'b1, exp_owner}));
  endtask

  // One full byte: grant, acceptance one cycle later, completion one cycle after that.
  task automatic serve(input string name, input logic [3:0] exp_gnt,
                       input logic [7:0] exp_data, input logic [1:0] exp_owner);
    wait_grant(name, exp_gnt, exp_data, exp_owner);
    pready = 1'b0;
    tick();
    check({name, " accept"}, 64'({tx_pdata_valid_o, busy_o}), 64'({1'b0, 1'b1}));
    pready = 1'b1;
    tick();
    exp_sent = exp_sent + 16'd1;
    check({name, " sent"}, 64'({sent_count_o, busy_o}), 64'({exp_sent, 1'b0}));
  endtask

  task automatic reset_in_wait_done(input string name);
    req    = 4'b0000;
    pready = 1'b0;
    tick();
    check({name, " in WAIT_DONE"}, 64'({tx_pdata_valid_o, busy_o}), 64'({1'b0, 1'b1}));
    #2 prst_n = 1'b0;
    #1;
    check({name, " async reset"}, 64'(outs()), 64'(0));
    tick();
    prst_n   = 1'b1;
    exp_sent = 16'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_valid;
    int n_err;

    // Reset state: asynchronous assertion before any clock edge is relied upon.
    #1 prst_n = 1'b0;
    #1 check("reset values", 64'(outs()), 64'(0));
    tick();
    tick();
    prst_n = 1'b1;

    // Cycle table: inputs applied, one edge, outputs compared.
    add(4'b0001, 32'h0000_003C, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    add(4'b0001, 32'h0000_003C, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    add(4'b0001, 32'h0000_003C, 1'b1, 4'b0001, 8'h3C, 1'b1, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b0000, 32'h0000_003C, 1'b1, 4'b0000, 8'h3C, 1'b1, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'h3C, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'h3C, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 8'h3C, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1);
    // Single request from requester 2, ready drops two cycles after valid.
    add(4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 8'hA5, 1'b1, 2'd2, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1, 1'b0, 16'd1);
    for (int i = 0; i < 10; i++)
      add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0, 1'b0, 16'd2);
    // Pointer now 3: search wraps 3,0,1.
    add(4'b0010, 32'h0000_5A00, 1'b1, 4'b0010, 8'h5A, 1'b1, 2'd1, 1'b1, 1'b0, 16'd2);
    add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'h5A, 1'b0, 2'd1, 1'b1, 1'b0, 16'd2);
    add(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 8'h5A, 1'b0, 2'd1, 1'b0, 1'b0, 16'd3);
    // Pointer 2: requesters 0 and 3 pending, 3 wins.
    add(4'b1001, 32'hC300_0011, 1'b1, 4'b1000, 8'hC3, 1'b1, 2'd3, 1'b1, 1'b0, 16'd3);
    add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'hC3, 1'b0, 2'd3, 1'b1, 1'b0, 16'd3);
    add(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 8'hC3, 1'b0, 2'd3, 1'b0, 1'b0, 16'd4);
    // Pointer 0: requester 0 wins; data changes in flight must not leak through.
    add(4'b1001, 32'hC300_0011, 1'b1, 4'b0001, 8'h11, 1'b1, 2'd0, 1'b1, 1'b0, 16'd4);
    add(4'b1001, 32'hEE00_00FF, 1'b0, 4'b0000, 8'h11, 1'b0, 2'd0, 1'b1, 1'b0, 16'd4);
    // Completion cycle with request and ready high: no grant on that edge.
    add(4'b1001, 32'hC300_0011, 1'b1, 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0, 1'b0, 16'd5);
    add(4'b1001, 32'hC300_0011, 1'b1, 4'b1000, 8'hC3, 1'b1, 2'd3, 1'b1, 1'b0, 16'd5);
    add(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'hC3, 1'b0, 2'd3, 1'b1, 1'b0, 16'd5);
    add(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 8'hC3, 1'b0, 2'd3, 1'b0, 1'b0, 16'd6);

    foreach (vecs[i]) begin
      req      = vecs[i].req;
      req_data = vecs[i].data;
      pready   = vecs[i].pready;
      tick();
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].gnt, vecs[i].pdata, vecs[i].valid, vecs[i].owner,
                 vecs[i].busy, vecs[i].err, vecs[i].cnt}));
    end
    exp_sent = 16'd6;
    req      = 4'b0000;

    // Round robin with all four requesting: pointer starts at 0.
    req      = 4'b1111;
    req_data = 32'h4433_2211;
    for (int k = 0; k < 8; k++) begin
      serve($sformatf("rr%0d", k), 4'(1 << (k % 4)), 8'(8'h11 * ((k % 4) + 1)), 2'(k % 4));
    end
    req = 4'b0000;

    // Acceptance timeout: requester 1, ready stuck high.
    req      = 4'b0010;
    req_data = 32'h0000_7700;
    wait_grant("timeout", 4'b0010, 8'h77, 2'd1);
    req     = 4'b0000;
    n_valid = tx_pdata_valid_o ? 1 : 0;
    n_err   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_pdata_valid_o) n_valid++;
      if (err_timeout_o)    n_err++;
    end
    check("timeout valid cycles", 64'(n_valid), 64'(16));
    check("timeout err pulses", 64'(n_err), 64'(1));
    check("timeout sent/busy", 64'({sent_count_o, busy_o}), 64'({exp_sent, 1'b0}));
    req      = 4'b1111;
    req_data = 32'h4433_2211;
    serve("after timeout", 4'b0100, 8'h33, 2'd2);
    req = 4'b0000;

    // Acceptance on the very cycle the limit is reached must win.
    req      = 4'b1000;
    req_data = 32'h5500_0000;
    wait_grant("tie", 4'b1000, 8'h55, 2'd3);
    req = 4'b0000;
    repeat (15) tick();
    pready = 1'b0;
    tick();
    check("tie accept", 64'({tx_pdata_valid_o, busy_o, err_timeout_o}), 64'({1'b0, 1'b1, 1'b0}));
    pready = 1'b1;
    tick();
    exp_sent = exp_sent + 16'd1;
    check("tie sent", 64'(sent_count_o), 64'(exp_sent));

    // Reset during WAIT_DONE with pointer at 2; afterwards the pointer must be 0.
    req      = 4'b0010;
    req_data = 32'h0000_9900;
    wait_grant("pre-reset", 4'b0010, 8'h99, 2'd1);
    reset_in_wait_done("reset1");
    req      = 4'b1010;
    req_data = 32'h8800_2200;
    wait_grant("post-reset ptr", 4'b0010, 8'h22, 2'd1);
    req    = 4'b0000;
    pready = 1'b0;
    tick();
    reset_in_wait_done("reset2");
    req      = 4'b1000;
    req_data = 32'h8800_0000;
    wait_grant("post-reset req3", 4'b1000, 8'h88, 2'd3);
    req    = 4'b0000;
    pready = 1'b0;
    tick();
    pready = 1'b1;
    tick();
    exp_sent = exp_sent + 16'd1;
    check("post-reset sent", 64'(sent_count_o), 64'(exp_sent));

    // Counter wrap.
    force dut.sent_count_o = 16'hFFFF;
    tick();
    release dut.sent_count_o;
    exp_sent = 16'hFFFF;
    req      = 4'b0001;
    req_data = 32'h0000_00AB;
    serve("wrap", 4'b0001, 8'hAB, 2'd0);
    req = 4'b0000;
    check("wrap to zero", 64'(sent_count_o), 64'(16'h0000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
